instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/issue controller: fetches from a registered-read RAM, issues words to the decoder,
// and resolves JZ/JNZ jumps and HALT. Define FETCH_RETIRE_COUNT_EN to enable the retired-instruction counter.
module instr_fetch_ctrl #(
    parameter int         PC_W     = 8,
    parameter int         PROG_LEN = 166,
    parameter logic [5:0] HALT_OP  = 6'd46,
    parameter logic [5:0] JZ_OP    = 6'd52,
    parameter logic [5:0] JNZ_OP   = 6'd47
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            dp_busy,
    input  logic            z_flag,
    output logic [PC_W-1:0] pc,
    output logic            done,
    output logic            overrun,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, BRANCH, HALT} state_t;

    localparam logic [31:0]     PROG_LEN_W = 32'(PROG_LEN);
    localparam logic [PC_W-1:0] PC_MAX     = '1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;

    logic [5:0] cap_op;
    logic [5:0] br_op;
    logic [9:0] br_operand;
    logic       pc_out_of_range;
    logic       br_taken;
    logic       br_target_bad;
    logic       advance;

    assign cap_op          = imem_data[15:10];
    assign br_op           = instr_q[15:10];
    assign br_operand      = instr_q[9:0];
    assign pc_out_of_range = 32'(pc_q) >= PROG_LEN_W;
    assign br_taken        = ((br_op == JZ_OP) && z_flag) || ((br_op == JNZ_OP) && !z_flag);
    // A target is bad if it is past the program or has operand bits the pc cannot hold.
    assign br_target_bad   = (32'(br_operand) >= PROG_LEN_W) || ((32'(br_operand) >> PC_W) != 32'd0);

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        done_d        = done_q;
        overrun_d     = overrun_q;
        advance       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (pc_out_of_range) begin
                    overrun_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                instr_d = imem_data;
                if (cap_op == HALT_OP) begin
                    done_d  = 1'b1;
                    state_d = HALT;
                end else if (cap_op == JZ_OP || cap_op == JNZ_OP) begin
                    state_d = BRANCH;
                end else begin
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    advance       = 1'b1;
                end
            end
            BRANCH: begin
                if (!dp_busy) begin
                    if (!br_taken) begin
                        advance = 1'b1;
                    end else if (br_target_bad) begin
                        overrun_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_d    = PC_W'(br_operand);
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                    pc_d      = '0;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Incrementing past the top of the pc range is an overrun rather than a silent wrap to 0.
        if (advance) begin
            if (pc_q == PC_MAX) begin
                overrun_d = 1'b1;
                state_d   = HALT;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every flop takes the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    // The RAM registers this address, so the word arrives in the cycle after FETCH.
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (start && (state_q == IDLE || state_q == HALT)) begin
            retired_d = '0;
        end else if (instr_valid_q && instr_ready && retired_q != 16'hFFFF) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: an instruction-level program interpreter predicts the issue stream
// and final status; directed cases pin latency, stalls, branches, reset and overrun with literal values.
module tb_instr_fetch_ctrl;

    localparam int         PC_W     = 8;
    localparam int         PROG_LEN = 166;
    localparam logic [5:0] HALT_OP  = 6'd46;
    localparam logic [5:0] JZ_OP    = 6'd52;
    localparam logic [5:0] JNZ_OP   = 6'd47;
    localparam logic [5:0] INAC_OP  = 6'd1;
    localparam logic [5:0] CLAC_OP  = 6'd2;

`ifdef FETCH_RETIRE_COUNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, start, instr_ready, dp_busy, z_flag;
    logic [PC_W-1:0] imem_addr, pc;
    logic [15:0]     imem_data, instr, retired;
    logic            instr_valid, done, overrun;
    logic [15:0]     ram [0:255];

    // Second instance with a 4-word program space for the run-off-the-end case.
    logic            start4;
    logic            ready4 = 1'b1;
    logic [PC_W-1:0] imem_addr4, pc4;
    logic [15:0]     imem_data4, instr4, retired4;
    logic            instr_valid4, done4, overrun4;
    logic [15:0]     ram4 [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) imem_data  <= ram[imem_addr];
    always @(posedge clk) imem_data4 <= ram4[imem_addr4];

    instr_fetch_ctrl #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .HALT_OP(HALT_OP), .JZ_OP(JZ_OP), .JNZ_OP(JNZ_OP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .dp_busy(dp_busy),
        .z_flag(z_flag), .pc(pc), .done(done), .overrun(overrun), .retired(retired)
    );

    instr_fetch_ctrl #(.PC_W(PC_W), .PROG_LEN(4), .HALT_OP(HALT_OP), .JZ_OP(JZ_OP), .JNZ_OP(JNZ_OP)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .imem_addr(imem_addr4), .imem_data(imem_data4),
        .instr(instr4), .instr_valid(instr_valid4), .instr_ready(ready4), .dp_busy(dp_busy),
        .z_flag(z_flag), .pc(pc4), .done(done4), .overrun(overrun4), .retired(retired4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [5:0] op, input int opd);
        return {op, 10'(opd)};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic [15:0]     w;
    } issue_t;

    issue_t exp_q[$];
    int     exp_pc;
    bit     exp_done, exp_ovr;
    int     acc_cnt  = 0;
    bit     fin_seen = 1'b0;
    bit     mon_en   = 1'b0;
    bit     drv_rand = 1'b0;

    // Runs the program at instruction level and records what must be issued and how it ends.
    task automatic model_run(input bit z);
        int          p = 0;
        int          opd;
        logic [15:0] w;
        logic [5:0]  op;
        bit          taken;
        exp_q.delete();
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        for (int step = 0; step < 1024; step++) begin
            if (p >= PROG_LEN) begin
                exp_ovr = 1'b1;
                break;
            end
            w   = ram[p];
            op  = w[15:10];
            opd = int'(w[9:0]);
            if (op == HALT_OP) begin
                exp_done = 1'b1;
                break;
            end
            if (op == JZ_OP || op == JNZ_OP) begin
                taken = (op == JZ_OP) ? z : !z;
                if (!taken) begin
                    p = p + 1;
                end else if (opd >= PROG_LEN) begin
                    exp_ovr = 1'b1;
                    break;
                end else begin
                    p = opd;
                end
            end else begin
                exp_q.push_back('{pc: PC_W'(p), w: w});
                p = p + 1;
            end
        end
        exp_pc = p;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("retired", retired, RC_EN ? 32'(acc_cnt) : 32'd0);
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_issue", 32'(instr_valid), 32'd0);
                end else begin
                    check("issue_instr", instr, exp_q[0].w);
                    check("issue_pc", pc, exp_q[0].pc);
                    if (instr_ready) begin
                        exp_q.delete(0);
                        acc_cnt++;
                    end
                end
            end
            if (fin_seen) begin
                check("halt_valid", 32'(instr_valid), 32'd0);
                check("halt_pc", pc, 32'(exp_pc));
            end else if (done || overrun) begin
                fin_seen = 1'b1;
                check("final_done", 32'(done), 32'(exp_done));
                check("final_overrun", 32'(overrun), 32'(exp_ovr));
                check("final_pc", pc, 32'(exp_pc));
                check("issues_left", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    // ---------------- random input driver ----------------
    always @(posedge clk) begin
        #1;
        if (drv_rand) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            dp_busy     = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic fill_ram(input logic [15:0] w);
        for (int i = 0; i < 256; i++) ram[i] = w;
    endtask

    task automatic gen_prog();
        for (int i = 0; i < 256; i++) begin
            int         r;
            logic [5:0] op;
            logic [9:0] opd;
            r   = int'($urandom_range(0, 99));
            opd = 10'($urandom);
            if (r < 2) begin
                op = HALT_OP;
            end else if (r < 22) begin
                op = (r < 12) ? JZ_OP : JNZ_OP;
                if (r % 5 == 0 || i >= PROG_LEN - 1) opd = 10'($urandom_range(PROG_LEN, 1023));
                else                                 opd = 10'($urandom_range(i + 1, PROG_LEN - 1));
            end else begin
                op = 6'($urandom);
                if (op == HALT_OP || op == JZ_OP || op == JNZ_OP) op = 6'd0;
            end
            ram[i] = {op, opd};
        end
    endtask

    // Ends one cycle after the edge that takes start, i.e. at the first FETCH cycle.
    task automatic start_prog(input bit z);
        mon_en = 1'b0;
        model_run(z);
        z_flag = z;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        acc_cnt  = 0;
        fin_seen = 1'b0;
        mon_en   = 1'b1;
    endtask

    task automatic wait_fin(input int budget);
        int c = 0;
        while (!fin_seen && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("program_finished", 32'(fin_seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic branch_test(input logic [5:0] first_op, input bit z, input int exp_addr);
        int c = 0;
        fill_ram(mk(HALT_OP, 0));
        ram[0]      = mk(first_op, 143);
        ram[143]    = mk(JZ_OP, 159);
        dp_busy     = 1'b0;
        instr_ready = 1'b1;
        start_prog(z);
        while (pc != PC_W'(143) && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_pc_143", pc, 32'd143);
        dp_busy = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("busy_pc_hold", pc, 32'd143);
        end
        dp_busy = 1'b0;
        @(posedge clk); #1;
        check("branch_imem_addr", imem_addr, 32'(exp_addr));
        wait_fin(100);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int ev[9];
        int epc[9];
        rst = 1'b0; start = 1'b0; start4 = 1'b0;
        instr_ready = 1'b0; dp_busy = 1'b0; z_flag = 1'b0;
        fill_ram(mk(HALT_OP, 0));
        for (int i = 0; i < 256; i++) ram4[i] = mk(6'd3, i);

        #3 rst = 1'b1;
        #1;
        check("rst_pc", pc, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_retired", retired, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_quiet_pc", pc, 32'd0);
        check("idle_quiet_valid", 32'(instr_valid), 32'd0);

        // INAC, CLAC, HALT with ready tied high: 2-cycle latency, one issue per 3 cycles.
        ram[0] = mk(INAC_OP, 5);
        ram[1] = mk(CLAC_OP, 9);
        ram[2] = mk(HALT_OP, 0);
        instr_ready = 1'b1;
        ev  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        epc = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        start_prog(1'b0);
        for (int i = 0; i < 9; i++) begin
            check("seq_valid", 32'(instr_valid), 32'(ev[i]));
            check("seq_pc", pc, 32'(epc[i]));
            check("seq_done", 32'(done), (i == 8) ? 32'd1 : 32'd0);
            if (i == 2) check("seq_instr0", instr, 32'h0405);
            if (i == 5) check("seq_instr1", instr, 32'h0809);
            if (i < 8) begin
                @(posedge clk); #1;
            end
        end
        wait_fin(50);
        check("seq_retired", retired, RC_EN ? 32'd2 : 32'd0);

        // Decoder stalls 5 cycles in ISSUE; a start pulse there is ignored.
        fill_ram(mk(HALT_OP, 0));
        ram[0] = mk(INAC_OP, 33);
        instr_ready = 1'b0;
        start_prog(1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("stall_valid_first", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(posedge clk); #1;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, 32'h0421);
            check("stall_pc", pc, 32'd0);
        end
        start = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        check("stall_release_valid", 32'(instr_valid), 32'd0);
        check("stall_release_pc", pc, 32'd1);
        wait_fin(50);
        check("stall_retired", retired, RC_EN ? 32'd1 : 32'd0);

        // JZ taken with z=1, then JZ not taken with z=0.
        branch_test(JZ_OP, 1'b1, 159);
        branch_test(JNZ_OP, 1'b0, 144);

        // Taken jump to an operand beyond the program space.
        fill_ram(mk(HALT_OP, 0));
        ram[0]   = mk(JNZ_OP, 163);
        ram[163] = mk(JNZ_OP, 300);
        start_prog(1'b0);
        wait_fin(100);
        check("jump_ovr_overrun", 32'(overrun), 32'd1);
        check("jump_ovr_done", 32'(done), 32'd0);
        check("jump_ovr_pc", pc, 32'd163);

        // Reset asserted mid-handshake, then restart from address 0.
        fill_ram(mk(HALT_OP, 0));
        ram[0] = mk(INAC_OP, 7);
        instr_ready = 1'b0;
        start_prog(1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_pc", pc, 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_retired", retired, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet_valid", 32'(instr_valid), 32'd0);
        check("post_rst_quiet_addr", imem_addr, 32'd0);
        instr_ready = 1'b1;
        start_prog(1'b0);
        check("restart_addr", imem_addr, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        check("restart_issue", instr, 32'h0407);
        wait_fin(50);

        // No HALT in a 4-word program: four issues then overrun at pc=4; start clears and restarts.
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && !overrun4; c++) begin
            if (instr_valid4) n++;
            @(posedge clk); #1;
        end
        check("len4_issues", 32'(n), 32'd4);
        check("len4_overrun", 32'(overrun4), 32'd1);
        check("len4_pc", pc4, 32'd4);
        check("len4_done", 32'(done4), 32'd0);
        check("len4_retired", retired4, RC_EN ? 32'd4 : 32'd0);
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        check("len4_restart_overrun", 32'(overrun4), 32'd0);
        check("len4_restart_pc", pc4, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        check("len4_restart_issue", instr4, 32'h0C00);

        // Randomized programs with random stalls and datapath busy.
        drv_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            gen_prog();
            start_prog(1'($urandom));
            wait_fin(6000);
        end
        drv_rand = 1'b0;
        mon_en   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
